pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// The datapath side drives the requests; the controller side drives the stall/flush results.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_busy;
  logic        ex_mc_last;
  logic [15:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, ex_mc_start, ex_mc_cycles,
           flush_req, flush_pc,
    input  stall, flush, new_pc, ex_mc_busy, ex_mc_last, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, ex_mc_start, ex_mc_cycles,
           flush_req, flush_pc,
    output stall, flush, new_pc, ex_mc_busy, ex_mc_last, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritised stall vector, flush redirect and a
// multi-cycle EX sequencer that holds the front of the pipe while a long op runs.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic        mc_launch;
  logic        fsm_ex_stall;
  logic        mc_last;
  logic [5:0]  stall_vec;

  // A launch only counts when it needs more than one cycle and is not being flushed away.
  always_comb begin
    mc_launch    = (state_q == IDLE) && bus.ex_mc_start && !bus.flush_req &&
                   (bus.ex_mc_cycles >= 6'd2);
    fsm_ex_stall = mc_launch || ((state_q == BUSY) && (cnt_q > 6'd1));
    mc_last      = (state_q == BUSY) && (cnt_q == 6'd1) && !bus.flush_req;
  end

  always_comb begin
    stall_vec = STALL_NONE;
    if (bus.flush_req) begin
      stall_vec = STALL_NONE;
    end else if (bus.stallreq_mem) begin
      stall_vec = STALL_MEM;
    end else if (bus.stallreq_ex || fsm_ex_stall) begin
      stall_vec = STALL_EX;
    end else if (bus.stallreq_id) begin
      stall_vec = STALL_ID;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;

    if (stall_vec[0] && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end

    if (bus.flush_req) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_launch) begin
            state_d = BUSY;
            cnt_d   = bus.ex_mc_cycles - 6'd1;
          end
        end
        BUSY: begin
          // A busy data bus freezes the whole sequencer, including the last cycle.
          if (!bus.stallreq_mem) begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end

    if (rst) begin
      state_d        = IDLE;
      cnt_d          = 6'd0;
      stall_cycles_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    cnt_q          <= cnt_d;
    stall_cycles_q <= stall_cycles_d;
  end

  always_comb begin
    bus.stall        = rst ? STALL_NONE : stall_vec;
    bus.flush        = !rst && bus.flush_req;
    bus.new_pc       = (!rst && bus.flush_req) ? bus.flush_pc : 32'h0;
    bus.ex_mc_busy   = !rst && (state_q == BUSY);
    bus.ex_mc_last   = !rst && mc_last;
    bus.stall_cycles = stall_cycles_q;
  end

endmodule
